servo_pwm_out: RTL

Servo pulse output stage sitting directly downstream of the servo position controller. It takes the controller's 12-bit pulse-width command in 1 µs units and produces the 50 Hz servo drive pulse on a pin. Between command and pin it applies:
- a 1 µs tick prescaler from `mclk`;
- a 20 ms frame counter;
- range clamping;
- per-frame slew limiting;
- frame-aligned enable, so pulses are never truncated or glitched.

---
 rtl/servo_pwm_out.sv | 127 ++++++++++++
 1 files changed

// File: rtl/servo_pwm_out.sv
// Servo pulse output stage: 1 us prescaler, 20 ms frame, clamp,
// per-frame slew limit and frame-aligned enable.
module servo_pwm_out #(
  parameter int TICK_DIV     = 50,
  parameter int PERIOD_TICKS = 20000,
  parameter int MIN_PW       = 500,
  parameter int MAX_PW       = 2500,
  parameter int INIT_PW      = 1500,
  parameter int MAX_STEP     = 20
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] control,
  output logic        pwm_out,
  output logic        frame_start,
  output logic [11:0] pw_active,
  output logic        clamped,
  output logic        settled
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PCW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int CW  = (PCW > 12) ? PCW : 12;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PCW-1:0] PER_LAST  = PCW'(PERIOD_TICKS - 1);
  localparam logic [11:0]    MIN_V     = 12'(MIN_PW);
  localparam logic [11:0]    MAX_V     = 12'(MAX_PW);
  localparam logic [11:0]    INIT_V    = 12'(INIT_PW);
  localparam logic [11:0]    STEP_V    = 12'(MAX_STEP);
  localparam logic [12:0]    STEP_M    = 13'(MAX_STEP);

  typedef enum logic {
    OFF,
    RUN
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [TW-1:0]  tick_cnt;
  logic [TW-1:0]  tick_cnt_n;
  logic [PCW-1:0] period_cnt;
  logic [PCW-1:0] period_cnt_n;
  logic [11:0]    target;
  logic [11:0]    target_n;
  logic [11:0]    pw_n;
  logic [11:0]    clamp_pw;
  logic           clamp_hit;
  logic [12:0]    diff;
  logic [12:0]    mag;
  logic [CW-1:0]  cnt_x;
  logic [CW-1:0]  pw_x;
  logic           tick;
  logic           boundary;
  logic           pwm_n;

  always_comb begin
    tick         = (tick_cnt == TICK_LAST);
    boundary     = tick && (period_cnt == PER_LAST);
    tick_cnt_n   = tick ? '0 : tick_cnt + 1'b1;
    period_cnt_n = period_cnt;
    if (boundary)
      period_cnt_n = '0;
    else if (tick)
      period_cnt_n = period_cnt + 1'b1;

    clamp_pw  = control;
    clamp_hit = 1'b0;
    if (control < MIN_V) begin
      clamp_pw  = MIN_V;
      clamp_hit = 1'b1;
    end else if (control > MAX_V) begin
      clamp_pw  = MAX_V;
      clamp_hit = 1'b1;
    end

    // 13-bit two's complement difference; bit 12 is the sign
    diff = {1'b0, clamp_pw} - {1'b0, pw_active};
    mag  = diff[12] ? (~diff + 13'd1) : diff;

    target_n = target;
    pw_n     = pw_active;
    state_n  = state;
    if (boundary) begin
      target_n = clamp_pw;
      state_n  = enable ? RUN : OFF;
      if (MAX_STEP == 0 || mag <= STEP_M)
        pw_n = clamp_pw;
      else if (diff[12])
        pw_n = pw_active - STEP_V;
      else
        pw_n = pw_active + STEP_V;
    end

    // look-ahead so the registered pin rises with frame_start
    cnt_x = CW'(period_cnt_n);
    pw_x  = CW'(pw_n);
    pwm_n = (state_n == RUN) && (cnt_x < pw_x);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFF;
      tick_cnt    <= '0;
      period_cnt  <= '0;
      target      <= INIT_V;
      pw_active   <= INIT_V;
      clamped     <= 1'b0;
      settled     <= 1'b1;
      frame_start <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_cnt_n;
      period_cnt  <= period_cnt_n;
      target      <= target_n;
      pw_active   <= pw_n;
      if (boundary)
        clamped <= clamp_hit;
      settled     <= (pw_n == target_n);
      frame_start <= boundary;
      pwm_out     <= pwm_n;
    end
  end

endmodule
